// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states, timeout default.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ACK_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mau_state_e;

    // Byte-lane view of a store as it leaves the unit.
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] wdata;
    } st_lane_t;

    // Size 11 behaves as a word, so anything not byte/half needs full alignment.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic res;
        case (sz)
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = lo[0];
            default: res = (lo != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store lane steering: byte strobes and replicated write data from size and address.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_store_align
    import mem_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_dat,
    output st_lane_t    lane
);

    always_comb begin
        lane.we    = 4'b0000;
        lane.wdata = st_dat;
        case (size)
            SZ_BYTE: begin
                lane.wdata = {4{st_dat[7:0]}};
                lane.we    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                lane.wdata = {2{st_dat[15:0]}};
                lane.we    = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                lane.wdata = st_dat;
                lane.we    = 4'b1111;
            end
        endcase
        // Loads never write; data lanes are don't-care then.
        if (!is_store) begin
            lane.we = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bus master: IDLE->BUSY->DONE per access, ack timeout, optional MEM_MISALIGN_CHECK_EN.
// Latency: 3 cycles minimum (stall 2); timeout after ACK_TIMEOUT BUSY cycles.
// Backpressure: mem_stall freezes the pipeline from request until the DONE cycle.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        EX_MEM_mem_rd,
    input  logic        EX_MEM_mem_wr,
    input  logic [1:0]  EX_MEM_mem_size,
    input  logic [31:0] EX_MEM_alu_c,
    input  logic [31:0] EX_MEM_rD2,
    input  logic        Bus_ack,
    input  logic [31:0] Bus_rdata_raw,
    output logic        Bus_req,
    output logic [31:0] Bus_addr,
    output logic [31:0] Bus_wdata,
    output logic [3:0]  Bus_we,
    output logic [31:0] Bus_rdata,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        mem_misalign
);

    localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 5) ? $clog2(ACK_TIMEOUT + 1) : 5;

    mau_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_err_q, bus_err_d;
    logic              access;
    logic              misalign_hit;
    st_lane_t          lane;

    // A simultaneous rd+wr is a store: is_store only looks at mem_wr.
    assign access = EX_MEM_mem_rd | EX_MEM_mem_wr;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_hit = access && is_misaligned(EX_MEM_mem_size, EX_MEM_alu_c[1:0]);
`else
    assign misalign_hit = 1'b0;
`endif

    mem_store_align u_store_align (
        .is_store (EX_MEM_mem_wr),
        .size     (EX_MEM_mem_size),
        .addr_lo  (EX_MEM_alu_c[1:0]),
        .st_dat   (EX_MEM_rD2),
        .lane     (lane)
    );

    assign Bus_addr  = EX_MEM_alu_c;
    assign Bus_we    = lane.we;
    assign Bus_wdata = lane.wdata;
    assign Bus_req   = bus_req_q;
    assign Bus_rdata = rdata_q;
    assign bus_err   = bus_err_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        rdata_d      = rdata_q;
        bus_err_d    = 1'b0;
        mem_stall    = 1'b0;
        mem_misalign = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d   = '0;
                mem_misalign = misalign_hit;
                if (access && !misalign_hit) begin
                    mem_stall = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                // Ack on the final allowed cycle still counts as a normal completion.
                if (Bus_ack) begin
                    rdata_d = Bus_rdata_raw;
                    state_d = ST_DONE;
                end else if (wait_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0000_0000;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
        bus_req_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rdata_q    <= 32'h0000_0000;
            bus_req_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            bus_req_q  <= bus_req_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, store lane steering, timeout, reset abort, misalign.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        EX_MEM_mem_rd;
    logic        EX_MEM_mem_wr;
    logic [1:0]  EX_MEM_mem_size;
    logic [31:0] EX_MEM_alu_c;
    logic [31:0] EX_MEM_rD2;
    logic        Bus_ack;
    logic [31:0] Bus_rdata_raw;
    logic        Bus_req;
    logic [31:0] Bus_addr;
    logic [31:0] Bus_wdata;
    logic [3:0]  Bus_we;
    logic [31:0] Bus_rdata;
    logic        mem_stall;
    logic        bus_err;
    logic        mem_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst         (cpu_rst),
        .EX_MEM_mem_rd   (EX_MEM_mem_rd),
        .EX_MEM_mem_wr   (EX_MEM_mem_wr),
        .EX_MEM_mem_size (EX_MEM_mem_size),
        .EX_MEM_alu_c    (EX_MEM_alu_c),
        .EX_MEM_rD2      (EX_MEM_rD2),
        .Bus_ack         (Bus_ack),
        .Bus_rdata_raw   (Bus_rdata_raw),
        .Bus_req         (Bus_req),
        .Bus_addr        (Bus_addr),
        .Bus_wdata       (Bus_wdata),
        .Bus_we          (Bus_we),
        .Bus_rdata       (Bus_rdata),
        .mem_stall       (mem_stall),
        .bus_err         (bus_err),
        .mem_misalign    (mem_misalign)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle. ack_at = BUSY cycle index (1-based) to ack, 0 = never.
    task automatic run_acc(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d,
                           input int ack_at, input logic [31:0] raw,
                           output int stalls, output int reqs, output int errs,
                           output logic [3:0] we0, output logic [31:0] wd0,
                           output logic [31:0] addr0, output logic [31:0] rdata_done);
        int  bidx;
        bit  done;
        stalls = 0; reqs = 0; errs = 0; bidx = 0; done = 1'b0;
        rdata_done = '0;
        EX_MEM_mem_rd = rd; EX_MEM_mem_wr = wr; EX_MEM_mem_size = sz;
        EX_MEM_alu_c = a; EX_MEM_rD2 = d;
        #1;
        we0 = Bus_we; wd0 = Bus_wdata; addr0 = Bus_addr;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge cpu_clk);
                @(negedge cpu_clk);
            end
            if (mem_stall) stalls++;
            if (Bus_req) begin
                reqs++;
                bidx++;
            end
            if (bus_err) errs++;
            Bus_ack       = Bus_req && (bidx == ack_at);
            Bus_rdata_raw = Bus_ack ? raw : 32'hFFFF_FFFF;
            if (cyc > 0 && !mem_stall) begin
                done = 1'b1;
                rdata_done = Bus_rdata;
                EX_MEM_mem_rd = 1'b0;
                EX_MEM_mem_wr = 1'b0;
            end
        end
        if (!done) check("acc_no_done", 32'd0, 32'd1);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    int          st, rq, er;
    logic [3:0]  we0;
    logic [31:0] wd0, ad0, rdt;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst = 1'b1;
        EX_MEM_mem_rd = 1'b0; EX_MEM_mem_wr = 1'b0; EX_MEM_mem_size = 2'b00;
        EX_MEM_alu_c = '0; EX_MEM_rD2 = '0; Bus_ack = 1'b0; Bus_rdata_raw = '0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_req",   32'(Bus_req),   32'd0);
        check("rst_rdata", Bus_rdata,      32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_err",   32'(bus_err),   32'd0);
        check("rst_mis",   32'(mem_misalign), 32'd0);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        // Load word 0x100, ack on first BUSY cycle
        run_acc(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1, 32'h1234_5678, st, rq, er, we0, wd0, ad0, rdt);
        check("lw_stall", 32'(st), 32'd2);
        check("lw_req",   32'(rq), 32'd1);
        check("lw_err",   32'(er), 32'd0);
        check("lw_rdata", rdt, 32'h1234_5678);
        check("lw_we",    32'(we0), 32'h0);
        check("lw_addr",  ad0, 32'h100);
        check("lw_hold",  Bus_rdata, 32'h1234_5678);

        // Store byte 0x103, ack on third BUSY cycle
        run_acc(1'b0, 1'b1, 2'b00, 32'h103, 32'h0000_00AB, 3, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("sb_we",    32'(we0), 32'h8);
        check("sb_wdata", wd0, 32'hABAB_ABAB);
        check("sb_req",   32'(rq), 32'd3);
        check("sb_stall", 32'(st), 32'd4);

        run_acc(1'b0, 1'b1, 2'b01, 32'h102, 32'h1234_CDEF, 1, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("sh_we",    32'(we0), 32'hC);
        check("sh_wdata", wd0, 32'hCDEF_CDEF);

        run_acc(1'b0, 1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF, 1, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("sw_we",    32'(we0), 32'hF);
        check("sw_wdata", wd0, 32'hDEAD_BEEF);

        // rd and wr together behave as a store
        run_acc(1'b1, 1'b1, 2'b00, 32'h001, 32'h0000_0042, 1, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("rw_we",    32'(we0), 32'h2);
        check("rw_wdata", wd0, 32'h4242_4242);

        run_acc(1'b0, 1'b1, 2'b11, 32'h300, 32'h0102_0304, 1, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("s11_we",   32'(we0), 32'hF);

        // No ack: timeout
        run_acc(1'b1, 1'b0, 2'b10, 32'h400, 32'h0, 0, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("to_req",   32'(rq), 32'd16);
        check("to_err",   32'(er), 32'd1);
        check("to_rdata", rdt, 32'h0);
        check("to_stall", 32'(st), 32'd17);
        check("to_idle",  32'(Bus_req), 32'd0);

        // Ack on the last allowed cycle wins
        run_acc(1'b1, 1'b0, 2'b10, 32'h404, 32'h0, 16, 32'hCAFE_F00D, st, rq, er, we0, wd0, ad0, rdt);
        check("l16_req",   32'(rq), 32'd16);
        check("l16_err",   32'(er), 32'd0);
        check("l16_rdata", rdt, 32'hCAFE_F00D);

        // Stray ack while idle
        Bus_ack = 1'b1; Bus_rdata_raw = 32'h0BAD_BEEF;
        @(posedge cpu_clk); @(negedge cpu_clk);
        Bus_ack = 1'b0;
        check("stray_rdata", Bus_rdata, 32'hCAFE_F00D);
        check("stray_req",   32'(Bus_req), 32'd0);

        // Reset in the 2nd BUSY cycle, stray ack afterwards
        EX_MEM_mem_rd = 1'b1; EX_MEM_mem_size = 2'b10; EX_MEM_alu_c = 32'h500;
        @(posedge cpu_clk); @(negedge cpu_clk);
        @(posedge cpu_clk); @(negedge cpu_clk);
        check("rb_req_busy", 32'(Bus_req), 32'd1);
        cpu_rst = 1'b1; EX_MEM_mem_rd = 1'b0;
        @(posedge cpu_clk); @(negedge cpu_clk);
        check("rb_req",   32'(Bus_req), 32'd0);
        check("rb_rdata", Bus_rdata, 32'd0);
        cpu_rst = 1'b0; Bus_ack = 1'b1; Bus_rdata_raw = 32'h5555_AAAA;
        @(posedge cpu_clk); @(negedge cpu_clk);
        Bus_ack = 1'b0;
        check("rb_ack_rdata", Bus_rdata, 32'd0);
        check("rb_ack_req",   32'(Bus_req), 32'd0);
        check("rb_ack_stall", 32'(mem_stall), 32'd0);

        run_acc(1'b1, 1'b0, 2'b10, 32'h600, 32'h0, 1, 32'h7777_1111, st, rq, er, we0, wd0, ad0, rdt);
        check("post_rst_stall", 32'(st), 32'd2);
        check("post_rst_rdata", rdt, 32'h7777_1111);

`ifdef MEM_MISALIGN_CHECK_EN
        EX_MEM_mem_rd = 1'b1; EX_MEM_mem_size = 2'b01; EX_MEM_alu_c = 32'h101;
        #1;
        check("mis_flag",  32'(mem_misalign), 32'd1);
        check("mis_stall", 32'(mem_stall), 32'd0);
        @(posedge cpu_clk); @(negedge cpu_clk);
        check("mis_req",   32'(Bus_req), 32'd0);
        EX_MEM_mem_rd = 1'b0;
        @(posedge cpu_clk); @(negedge cpu_clk);
        check("mis_req2",  32'(Bus_req), 32'd0);
`else
        EX_MEM_mem_wr = 1'b1; EX_MEM_mem_size = 2'b01; EX_MEM_alu_c = 32'h101;
        #1;
        check("mis_flag",  32'(mem_misalign), 32'd0);
        EX_MEM_mem_wr = 1'b0;
        run_acc(1'b0, 1'b1, 2'b01, 32'h101, 32'h0000_BEEF, 1, 32'h0, st, rq, er, we0, wd0, ad0, rdt);
        check("mis_we",    32'(we0), 32'h3);
        check("mis_stall", 32'(st), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
